// File: rtl/booth_recoder.sv
// rtl/booth_recoder.sv - sequential radix-4 Booth recoder, one select code per handshake
module booth_recoder #(
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_sel,
   output logic [1:0] out_idx,
   output logic       out_last
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t     state, state_nx;
   logic [8:0] opnd, opnd_nx;
   logic       valid_nx;
   logic [2:0] sel_nx;
   logic [1:0] idx_nx;
   logic       last_nx;

   logic       fire;
   logic       load;
   logic [8:0] new_opnd;
   logic [3:0] new_mask, cur_mask;
   logic [1:0] new_first, new_high, cur_next, cur_high;

   // Triplet (b[2i+1], b[2i], b[2i-1]) to {inv, shift}; zero is always 000
   function automatic logic [2:0] booth_sel(input logic [2:0] t);
      case (t)
         3'b001, 3'b010: return 3'b001;
         3'b011:         return 3'b010;
         3'b100:         return 3'b110;
         3'b101, 3'b110: return 3'b101;
         default:        return 3'b000;
      endcase
   endfunction

   // Operand register bit 0 is the implicit b[-1], so digit i sits at [2i+2:2i]
   function automatic logic [2:0] digit_sel(input logic [8:0] b, input logic [1:0] i);
      return booth_sel(b[{1'b0, i, 1'b0} +: 3]);
   endfunction

   // Which digit positions get emitted; all-zero operands still emit idx 0
   function automatic logic [3:0] emit_mask(input logic [8:0] b);
      logic [3:0] m;
      for (int i = 0; i < 4; i++) begin
         m[i] = (digit_sel(b, 2'(i)) != 3'b000);
      end
      if (!SKIP_ZERO) begin
         m = 4'b1111;
      end else if (m == 4'b0000) begin
         m = 4'b0001;
      end
      return m;
   endfunction

   function automatic logic [1:0] lowest_from(input logic [3:0] m, input logic [2:0] floor);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= floor)) begin
            r = 2'(i);
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] highest(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            r = 2'(i);
         end
      end
      return r;
   endfunction

   assign fire      = out_valid & out_ready;
   assign in_ready  = rst_n & ((state == IDLE) | (fire & out_last));
   assign load      = in_valid & in_ready;
   assign new_opnd  = {in_data, 1'b0};
   assign new_mask  = emit_mask(new_opnd);
   assign new_first = lowest_from(new_mask, 3'd0);
   assign new_high  = highest(new_mask);
   assign cur_mask  = emit_mask(opnd);
   assign cur_next  = lowest_from(cur_mask, {1'b0, out_idx} + 3'd1);
   assign cur_high  = highest(cur_mask);

   // Next state and next registered outputs: load wins, otherwise advance on handshake
   always_comb begin
      state_nx = state;
      opnd_nx  = opnd;
      valid_nx = out_valid;
      sel_nx   = out_sel;
      idx_nx   = out_idx;
      last_nx  = out_last;
      if (load) begin
         state_nx = EMIT;
         opnd_nx  = new_opnd;
         valid_nx = 1'b1;
         idx_nx   = new_first;
         sel_nx   = digit_sel(new_opnd, new_first);
         last_nx  = (new_first == new_high);
      end else if (fire) begin
         if (out_last) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end else begin
            idx_nx  = cur_next;
            sel_nx  = digit_sel(opnd, cur_next);
            last_nx = (cur_next == cur_high);
         end
      end
   end

   // State, operand and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         opnd      <= 9'd0;
         out_valid <= 1'b0;
         out_sel   <= 3'b000;
         out_idx   <= 2'd0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nx;
         opnd      <= opnd_nx;
         out_valid <= valid_nx;
         out_sel   <= sel_nx;
         out_idx   <= idx_nx;
         out_last  <= last_nx;
      end
   end

endmodule

// File: tb/tb_booth_recoder.sv
// tb/tb_booth_recoder.sv - randomized and directed bench for booth_recoder, both SKIP_ZERO settings
module tb_booth_recoder;

   typedef struct {
      logic [1:0] idx;
      logic [2:0] sel;
      logic       last;
      int         cyc;
   } dig_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [7:0] in_data   [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [2:0] out_sel   [2];
   logic [1:0] out_idx   [2];
   logic       out_last  [2];

   int   checks = 0;
   int   errors = 0;

   logic [7:0] op_q  [$];
   dig_t       got_q [$];
   dig_t       exp_q [$];
   int         acc_q [$];
   int         unstable;
   bit         timed_out;

   always #5 clk = ~clk;

   booth_recoder #(.SKIP_ZERO(1'b0)) u_plain (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_sel(out_sel[0]), .out_idx(out_idx[0]), .out_last(out_last[0])
   );

   booth_recoder #(.SKIP_ZERO(1'b1)) u_skip (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_sel(out_sel[1]), .out_idx(out_idx[1]), .out_last(out_last[1])
   );

   // Reference: Booth digit value d_i = -2*b[2i+1] + b[2i] + b[2i-1], with b[-1] = 0
   function automatic int booth_val(input logic [7:0] v, input int i);
      int hi, mid, lo;
      hi  = int'(v[2*i+1]);
      mid = int'(v[2*i]);
      lo  = (i == 0) ? 0 : int'(v[2*i-1]);
      return -2 * hi + mid + lo;
   endfunction

   function automatic logic [2:0] enc(input int d);
      case (d)
         1:       return 3'b001;
         2:       return 3'b010;
         -1:      return 3'b101;
         -2:      return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   function automatic int dec(input logic [2:0] s);
      int mag;
      mag = (s[1:0] == 2'b10) ? 2 : (s[1:0] == 2'b01) ? 1 : 0;
      return s[2] ? -mag : mag;
   endfunction

   task automatic build_exp(input logic [7:0] v, input bit skip);
      int nz [$];
      for (int i = 0; i < 4; i++) begin
         if (!skip || booth_val(v, i) != 0) nz.push_back(i);
      end
      if (nz.size() == 0) nz.push_back(0);
      foreach (nz[k]) begin
         exp_q.push_back('{2'(nz[k]), enc(booth_val(v, nz[k])), (k == nz.size() - 1), 0});
      end
   endtask

   // Drives op_q into DUT d and records every accept and digit handshake with its cycle
   task automatic run_ops(input int d, input bit rnd, input int max_cyc);
      int         cyc, sent, nlast, n;
      bit         hold;
      logic [6:0] prev;
      n = op_q.size(); cyc = 0; sent = 0; nlast = 0; hold = 0; prev = '0;
      got_q.delete(); acc_q.delete(); unstable = 0; timed_out = 0;
      while (nlast < n) begin
         @(negedge clk);
         if (hold && {out_valid[d], out_idx[d], out_sel[d], out_last[d]} !== prev) unstable++;
         in_valid[d]  = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
         in_data[d]   = in_valid[d] ? op_q[sent] : 8'($urandom);
         out_ready[d] = !rnd || ($urandom_range(0, 2) != 0);
         #1;
         if (in_valid[d] && in_ready[d]) begin
            acc_q.push_back(cyc);
            sent++;
         end
         if (out_valid[d] && out_ready[d]) begin
            got_q.push_back('{out_idx[d], out_sel[d], out_last[d], cyc});
            if (out_last[d]) nlast++;
         end
         hold = out_valid[d] && !out_ready[d];
         prev = {out_valid[d], out_idx[d], out_sel[d], out_last[d]};
         cyc++;
         if (cyc >= max_cyc) begin
            timed_out = 1;
            break;
         end
      end
      in_valid[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; in_data[d] = 8'h00; out_ready[d] = 1'b1;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (out_valid[d] !== 1'b0)  begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", d, out_valid[d]); end
         checks++; if (out_sel[d] !== 3'b000)  begin errors++; $display("FAIL reset_sel[%0d]: got %b want 000", d, out_sel[d]); end
         checks++; if (out_idx[d] !== 2'd0)    begin errors++; $display("FAIL reset_idx[%0d]: got %0d want 0", d, out_idx[d]); end
         checks++; if (out_last[d] !== 1'b0)   begin errors++; $display("FAIL reset_last[%0d]: got %b want 0", d, out_last[d]); end
         checks++; if (in_ready[d] !== 1'b1)   begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
      end
   endtask

   task automatic test_directed();
      int         dsel [5] = '{0, 0, 1, 1, 1};
      logic [7:0] vals [5] = '{8'h80, 8'h7F, 8'h80, 8'h00, 8'h7F};
      for (int t = 0; t < 5; t++) begin
         op_q.delete(); op_q.push_back(vals[t]);
         exp_q.delete(); build_exp(vals[t], dsel[t] == 1);
         run_ops(dsel[t], 0, 50);
         checks++; if (timed_out) begin errors++; $display("FAIL dir_timeout[%0d]: got timeout want completion", t); end
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL dir_count[%0d]: got %0d want %0d", t, got_q.size(), exp_q.size()); end
         for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k].idx !== exp_q[k].idx || got_q[k].sel !== exp_q[k].sel || got_q[k].last !== exp_q[k].last) begin
               errors++;
               $display("FAIL dir_digit[%0d.%0d]: got idx%0d sel%b last%b want idx%0d sel%b last%b", t, k,
                        got_q[k].idx, got_q[k].sel, got_q[k].last, exp_q[k].idx, exp_q[k].sel, exp_q[k].last);
            end
            checks++;
            if (acc_q.size() > 0 && got_q[k].cyc !== acc_q[0] + 1 + k) begin
               errors++; $display("FAIL dir_timing[%0d.%0d]: got cycle %0d want %0d", t, k, got_q[k].cyc, acc_q[0] + 1 + k);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      op_q.delete(); op_q.push_back(8'h01); op_q.push_back(8'hFF);
      exp_q.delete(); build_exp(8'h01, 0); build_exp(8'hFF, 0);
      run_ops(0, 0, 50);
      checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got timeout want completion"); end
      checks++; if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k].idx !== exp_q[k].idx || got_q[k].sel !== exp_q[k].sel || got_q[k].last !== exp_q[k].last) begin
            errors++;
            $display("FAIL b2b_digit[%0d]: got idx%0d sel%b last%b want idx%0d sel%b last%b", k,
                     got_q[k].idx, got_q[k].sel, got_q[k].last, exp_q[k].idx, exp_q[k].sel, exp_q[k].last);
         end
         checks++;
         if (got_q[k].cyc !== got_q[0].cyc + k) begin
            errors++; $display("FAIL b2b_bubble[%0d]: got cycle %0d want %0d", k, got_q[k].cyc, got_q[0].cyc + k);
         end
      end
      checks++;
      if (acc_q.size() != 2 || got_q.size() < 4 || acc_q[1] !== got_q[3].cyc) begin
         errors++; $display("FAIL b2b_second_accept: got %0d accepts want second on last-digit cycle", acc_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [2:0] tail_sel [3] = '{3'b000, 3'b000, 3'b010};
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 8'h7F; out_ready[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0; in_data[0] = 8'hA5; out_ready[0] = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (s > 0) @(negedge clk);
         #1;
         checks++;
         if (out_valid[0] !== 1'b1 || out_idx[0] !== 2'd0 || out_sel[0] !== 3'b101 || out_last[0] !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d]: got v%b idx%0d sel%b last%b want v1 idx0 sel101 last0", s,
                               out_valid[0], out_idx[0], out_sel[0], out_last[0]);
         end
         checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", s, in_ready[0]); end
      end
      @(negedge clk);
      out_ready[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid[0] !== 1'b1 || out_idx[0] !== 2'(k + 1) || out_sel[0] !== tail_sel[k] || out_last[0] !== (k == 2)) begin
            errors++; $display("FAIL bp_tail[%0d]: got v%b idx%0d sel%b last%b want v1 idx%0d sel%b last%b", k,
                               out_valid[0], out_idx[0], out_sel[0], out_last[0], k + 1, tail_sel[k], (k == 2));
         end
      end
      @(negedge clk);
      #1;
      checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", out_valid[0]); end
   endtask

   task automatic test_random();
      for (int d = 0; d < 2; d++) begin
         int k;
         int sum;
         op_q.delete(); exp_q.delete();
         for (int i = 0; i < 30; i++) begin
            logic [7:0] v;
            v = (i == 0) ? 8'h00 : (i == 1) ? 8'h80 : 8'($urandom);
            op_q.push_back(v);
            build_exp(v, d == 1);
         end
         run_ops(d, 1, 3000);
         checks++; if (timed_out) begin errors++; $display("FAIL rnd_timeout[%0d]: got timeout want completion", d); end
         checks++; if (unstable != 0) begin errors++; $display("FAIL rnd_stall_stable[%0d]: got %0d changes want 0", d, unstable); end
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", d, got_q.size(), exp_q.size()); end
         for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_q[j].idx !== exp_q[j].idx || got_q[j].sel !== exp_q[j].sel || got_q[j].last !== exp_q[j].last) begin
               errors++;
               $display("FAIL rnd_digit[%0d.%0d]: got idx%0d sel%b last%b want idx%0d sel%b last%b", d, j,
                        got_q[j].idx, got_q[j].sel, got_q[j].last, exp_q[j].idx, exp_q[j].sel, exp_q[j].last);
            end
         end
         k = 0; sum = 0;
         foreach (got_q[j]) begin
            sum += dec(got_q[j].sel) * (1 << (2 * got_q[j].idx));
            if (got_q[j].last) begin
               checks++;
               if (k < op_q.size() && sum != int'($signed(op_q[k]))) begin
                  errors++; $display("FAIL rnd_value[%0d.%0d]: got %0d want %0d", d, k, sum, int'($signed(op_q[k])));
               end
               k++; sum = 0;
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 8'h7F; out_ready[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (out_idx[0] !== 2'd2) begin errors++; $display("FAIL mid_reach_idx2: got %0d want 2", out_idx[0]); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid[0]); end
      checks++; if (out_idx[0] !== 2'd0)   begin errors++; $display("FAIL mid_idx: got %0d want 0", out_idx[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready[0] !== 1'b1)  begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready[0]); end
      op_q.delete(); op_q.push_back(8'h01);
      run_ops(0, 0, 50);
      checks++;
      if (timed_out || got_q.size() != 4 || got_q[0].idx !== 2'd0 || got_q[0].sel !== 3'b001) begin
         errors++; $display("FAIL mid_fresh: got %0d digits first idx%0d sel%b want 4 digits idx0 sel001",
                            got_q.size(), (got_q.size() > 0) ? got_q[0].idx : 2'd0, (got_q.size() > 0) ? got_q[0].sel : 3'd0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
